cdb_broadcast: RTL and testbench

CDB_BROADCAST -- requirements
Module: cdb_broadcast

---
 rtl/cdb_broadcast.sv | 148 ++++++++++++++
 tb/tb_cdb_broadcast.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast.sv
// cdb_broadcast: per-FU result FIFOs arbitrated round-robin onto
// up to CDB_PORTS registered common-data-bus wakeup lanes.
// Lanes j: 0 LSU, 1 MULT, 2 BTU, 3 ALU.
// Ports:
//   clk, reset (async, active-low)
//   fu_valid/fu_tag/fu_value -> push into FIFO j; fu_ready back
//   squash                   -> flush all buffered results
//   wakeup/wakeup_tag/value  -> registered broadcast per lane
module cdb_broadcast #(
  parameter int CDB_PORTS   = 2,
  parameter int FIFO_DEPTH  = 2,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  fu_valid,
  input  logic [3:0][ROB_TAG_LEN-1:0] fu_tag,
  input  logic [3:0][XLEN-1:0]        fu_value,
  output logic [3:0]                  fu_ready,
  input  logic                        squash,
  output logic [3:0]                  wakeup,
  output logic [3:0][ROB_TAG_LEN-1:0] wakeup_tag,
  output logic [3:0][XLEN-1:0]        wakeup_value
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [2:0]    PORTS_C = 3'(CDB_PORTS);

  logic [ROB_TAG_LEN-1:0] tag_mem [4][FIFO_DEPTH];
  logic [XLEN-1:0]        val_mem [4][FIFO_DEPTH];

  logic [3:0][PW-1:0] head_q, head_d;
  logic [3:0][PW-1:0] tail_q, tail_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         rr_q, rr_d;

  logic [3:0]                  wk_q, wk_d;
  logic [3:0][ROB_TAG_LEN-1:0] tag_q, tag_d;
  logic [3:0][XLEN-1:0]        val_q, val_d;

  logic [3:0] push;
  logic [3:0] gnt;
  logic [2:0] ngnt;
  logic [1:0] idx;
  logic [1:0] last;

  // Ready comes from the registered count only, so a pop in
  // the same cycle never opens a slot early.
  always_comb begin
    fu_ready = '0;
    for (int j = 0; j < 4; j++) begin
      fu_ready[j] = reset & (cnt_q[j] < DEPTH_C);
    end
  end

  assign push = fu_valid & fu_ready;

  // Round-robin scan from rr_q, granting at most CDB_PORTS
  // non-empty FIFOs; the pointer moves past the last winner.
  always_comb begin
    gnt  = '0;
    ngnt = '0;
    last = rr_q;
    idx  = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (cnt_q[idx] != '0 && ngnt < PORTS_C) begin
        gnt[idx] = 1'b1;
        ngnt     = ngnt + 3'd1;
        last     = idx;
      end
    end
    rr_d = (|gnt) ? last + 2'd1 : rr_q;
    if (squash) begin
      rr_d = '0;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    wk_d   = '0;
    tag_d  = '0;
    val_d  = '0;
    for (int j = 0; j < 4; j++) begin
      if (gnt[j]) begin
        head_d[j] = head_q[j] + PW'(1);
        wk_d[j]   = 1'b1;
        tag_d[j]  = tag_mem[j][head_q[j]];
        val_d[j]  = val_mem[j][head_q[j]];
      end
      if (push[j]) begin
        tail_d[j] = tail_q[j] + PW'(1);
      end
      cnt_d[j] = cnt_q[j]
               + {{PW{1'b0}}, push[j]}
               - {{PW{1'b0}}, gnt[j]};
    end
    // Flush wins over both pushes and grants.
    if (squash) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      wk_d   = '0;
      tag_d  = '0;
      val_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
      wk_q   <= '0;
      tag_q  <= '0;
      val_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      wk_q   <= wk_d;
      tag_q  <= tag_d;
      val_q  <= val_d;
    end
  end

  // Storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (push[j]) begin
        tag_mem[j][tail_q[j]] <= fu_tag[j];
        val_mem[j][tail_q[j]] <= fu_value[j];
      end
    end
  end

  assign wakeup       = wk_q;
  assign wakeup_tag   = tag_q;
  assign wakeup_value = val_q;

endmodule

// File: tb/tb_cdb_broadcast.sv
// tb_cdb_broadcast: directed + random checks of cdb_broadcast
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_cdb_broadcast;

  localparam int PORTS = 2;
  localparam int DEPTH = 2;
  localparam int XW    = 32;
  localparam int TW    = 6;

  logic clk = 1'b0;
  bit   run = 1'b0;
  always #5 if (run) clk = ~clk;

  logic                 reset;
  logic [3:0]           fu_valid;
  logic [3:0][TW-1:0]   fu_tag;
  logic [3:0][XW-1:0]   fu_value;
  logic [3:0]           fu_ready;
  logic                 squash;
  logic [3:0]           wakeup;
  logic [3:0][TW-1:0]   wakeup_tag;
  logic [3:0][XW-1:0]   wakeup_value;

  cdb_broadcast #(
    .CDB_PORTS(PORTS),
    .FIFO_DEPTH(DEPTH),
    .XLEN(XW),
    .ROB_TAG_LEN(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fu_valid(fu_valid),
    .fu_tag(fu_tag),
    .fu_value(fu_value),
    .fu_ready(fu_ready),
    .squash(squash),
    .wakeup(wakeup),
    .wakeup_tag(wakeup_tag),
    .wakeup_value(wakeup_value)
  );

  typedef struct packed {
    logic [TW-1:0] t;
    logic [XW-1:0] d;
  } ent_t;

  ent_t               q [4][$];
  int                 m_rr;
  logic               m_rst;
  logic [3:0]         exp_wk;
  logic [3:0][TW-1:0] exp_tag;
  logic [3:0][XW-1:0] exp_val;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tg,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4; j++) q[j].delete();
    m_rr    = 0;
    exp_wk  = '0;
    exp_tag = '0;
    exp_val = '0;
  endtask

  // One clock edge of the reference: arbitrate over the
  // pre-edge queues, then append accepted pushes.
  task automatic model_step(input logic [3:0] v,
                            input logic [3:0][TW-1:0] t,
                            input logic [3:0][XW-1:0] d,
                            input logic sq,
                            output logic [3:0] acc);
    int n;
    int last;
    int i;
    ent_t e;
    acc = '0;
    for (int j = 0; j < 4; j++)
      acc[j] = v[j] && (q[j].size() < DEPTH) && !sq;
    exp_wk  = '0;
    exp_tag = '0;
    exp_val = '0;
    if (sq) begin
      for (int j = 0; j < 4; j++) q[j].delete();
      m_rr = 0;
    end else begin
      n    = 0;
      last = 0;
      for (int k = 0; k < 4; k++) begin
        i = (m_rr + k) % 4;
        if (q[i].size() > 0 && n < PORTS) begin
          e = q[i].pop_front();
          exp_wk[i]  = 1'b1;
          exp_tag[i] = e.t;
          exp_val[i] = e.d;
          n++;
          last = i;
        end
      end
      if (n > 0) m_rr = (last + 1) % 4;
      for (int j = 0; j < 4; j++) begin
        if (acc[j]) begin
          e.t = t[j];
          e.d = d[j];
          q[j].push_back(e);
        end
      end
    end
  endtask

  task automatic cmp_all();
    logic [3:0] er;
    for (int j = 0; j < 4; j++)
      er[j] = m_rst && (q[j].size() < DEPTH);
    check("wakeup", 128'(wakeup), 128'(exp_wk));
    check("wk_tag", 128'(wakeup_tag), 128'(exp_tag));
    check("wk_val", 128'(wakeup_value), 128'(exp_val));
    check("fu_ready", 128'(fu_ready), 128'(er));
  endtask

  task automatic cycle(input logic [3:0] v,
                       input logic [3:0][TW-1:0] t,
                       input logic [3:0][XW-1:0] d,
                       input logic sq,
                       output logic [3:0] acc);
    fu_valid = v;
    fu_tag   = t;
    fu_value = d;
    squash   = sq;
    model_step(v, t, d, sq, acc);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic idle();
    logic [3:0] a;
    cycle('0, '0, '0, 1'b0, a);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [3:0]         acc;
  logic [3:0][TW-1:0] t;
  logic [3:0][XW-1:0] d;
  logic [3:0]         pv;
  logic [3:0][TW-1:0] pt;
  logic [3:0][XW-1:0] pd;
  logic               sq;
  int                 ctr;

  initial begin
    reset    = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;
    squash   = 1'b0;
    m_rst    = 1'b0;
    model_reset();

    // Reset with the clock stopped.
    #3;
    check("rst_wakeup", 128'(wakeup), 128'(0));
    check("rst_tag", 128'(wakeup_tag), 128'(0));
    check("rst_val", 128'(wakeup_value), 128'(0));
    check("rst_ready", 128'(fu_ready), 128'(0));
    #2 reset = 1'b1;
    m_rst = 1'b1;
    #1;
    check("rel_ready", 128'(fu_ready), 128'(4'hF));
    run = 1'b1;
    @(negedge clk);
    cmp_all();

    // Single ALU result.
    t = '0; d = '0;
    t[3] = TW'(5); d[3] = 32'hDEAD;
    cycle(4'b1000, t, d, 1'b0, acc);
    check("single_nobyp", 128'(wakeup), 128'(0));
    idle();
    check("single_wk", 128'(wakeup), 128'(4'b1000));
    check("single_tag", 128'(wakeup_tag[3]), 128'(5));
    check("single_val", 128'(wakeup_value[3]), 128'(32'hDEAD));
    idle();
    check("single_clr", 128'(wakeup), 128'(0));

    // Contention across all four FUs.
    for (int j = 0; j < 4; j++) begin
      t[j] = TW'(j + 1);
      d[j] = 32'(100 + j);
    end
    cycle(4'hF, t, d, 1'b0, acc);
    idle();
    check("cont_a", 128'(wakeup), 128'(4'b0011));
    idle();
    check("cont_b", 128'(wakeup), 128'(4'b1100));
    cycle(4'hF, t, d, 1'b0, acc);
    idle();
    check("cont_rr0", 128'(wakeup), 128'(4'b0011));
    idle();
    idle();

    // Squash with buffered entries and a same-cycle push.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        t[j] = TW'(40 + 4 * k + j);
        d[j] = $urandom;
      end
      cycle(4'hF, t, d, 1'b0, acc);
    end
    for (int j = 0; j < 4; j++) t[j] = TW'(60 + j);
    cycle(4'hF, t, d, 1'b1, acc);
    check("sq_wk", 128'(wakeup), 128'(0));
    check("sq_ready", 128'(fu_ready), 128'(4'hF));
    for (int k = 0; k < 3; k++) begin
      idle();
      check("sq_after", 128'(wakeup), 128'(0));
    end

    // Async reset while LSU and BTU are broadcasting.
    t = '0;
    for (int j = 0; j < 4; j++) d[j] = $urandom;
    t[0] = TW'(11); t[2] = TW'(12);
    cycle(4'b0101, t, d, 1'b0, acc);
    t[0] = TW'(13); t[2] = TW'(14);
    cycle(4'b0101, t, d, 1'b0, acc);
    check("ar_pre", 128'(wakeup), 128'(4'b0101));
    fu_valid = '0;
    #2 reset = 1'b0;
    m_rst = 1'b0;
    model_reset();
    #1;
    check("ar_wk", 128'(wakeup), 128'(0));
    check("ar_tag", 128'(wakeup_tag), 128'(0));
    check("ar_ready", 128'(fu_ready), 128'(0));
    #1 reset = 1'b1;
    m_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      check("ar_after", 128'(wakeup), 128'(0));
    end

    // Random traffic; FUs hold a result until accepted.
    pv  = '0;
    pt  = '0;
    pd  = '0;
    ctr = 1;
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 4; j++) begin
        if (!pv[j] && $urandom_range(0, 3) != 0) begin
          pv[j] = 1'b1;
          pt[j] = TW'(ctr);
          pd[j] = $urandom;
          ctr++;
        end
      end
      sq = ($urandom_range(0, 49) == 0);
      cycle(pv, pt, pd, sq, acc);
      if (sq) pv = '0;
      else    pv = pv & ~acc;
    end
    for (int k = 0; k < 6; k++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
